// File: rtl/regfile.sv
// 32x32 register file: one synchronous write port, two combinational read ports
// with same-cycle write-to-read bypass; the ZERO_REG entry always reads as zero.
module regfile #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 31
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [$clog2(NUM_REGS)-1:0] ReadRegister1,
  input  logic [$clog2(NUM_REGS)-1:0] ReadRegister2,
  input  logic [$clog2(NUM_REGS)-1:0] WriteRegister,
  input  logic [DATA_W-1:0]           WriteData,
  input  logic                        RegWrite,
  output logic [DATA_W-1:0]           ReadData1,
  output logic [DATA_W-1:0]           ReadData2
);

  localparam int                 ADDR_W    = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0]  ZERO_ADDR = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0]   mem [NUM_REGS];
  logic [NUM_REGS-1:0] wr_en;
  logic                bypass1;
  logic                bypass2;

  // Write decoder: one-hot enable gated by RegWrite, never selecting the zero register.
  always_comb begin
    // NOTE: default every always_comb output first so no path leaves it unassigned (no latch).
    wr_en = '0;
    if (RegWrite) begin
      wr_en[WriteRegister] = 1'b1;
    end
    wr_en[ZERO_REG] = 1'b0;
  end

  // NOTE: the storage array is cleared by reset because a read must never return X.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        mem[i] <= '0;
      end else if (wr_en[i]) begin
        mem[i] <= WriteData;
      end
    end
  end

  assign bypass1 = RegWrite && (WriteRegister == ReadRegister1) && (ReadRegister1 != ZERO_ADDR);
  assign bypass2 = RegWrite && (WriteRegister == ReadRegister2) && (ReadRegister2 != ZERO_ADDR);

  // Zero register is forced in the mux so it reads 0 even before any write or reset.
  assign ReadData1 = (ReadRegister1 == ZERO_ADDR) ? '0
                   : bypass1                      ? WriteData
                   :                                mem[ReadRegister1];
  assign ReadData2 = (ReadRegister2 == ZERO_ADDR) ? '0
                   : bypass2                      ? WriteData
                   :                                mem[ReadRegister2];

endmodule
